// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encoding, command word layout and next-set-op search
package alu_pkg;
  localparam int ALU_W = 3;
  typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, AND = 2'b10, OR = 2'b11} alu_op_t;
  typedef struct packed {
    logic [ALU_W-1:0] a;
    alu_op_t          f;
    logic [ALU_W-1:0] b;
  } alu_word_t;
  function automatic logic [1:0] next_op(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] n;
    next_op = cur;
    for (int i = 4; i >= 1; i--) begin
      n = cur + 2'(i);
      if (m[n]) next_op = n;
    end
  endfunction
endpackage

// File: rtl/alu_display_rotator.sv
// alu_display_rotator: dwell counter cycling through valid ops in ascending order with wrap
module alu_display_rotator
  import alu_pkg::*;
#(
  parameter int DWELL = 50
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] res_valid,
  output logic [1:0] op
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic          run;
  logic [1:0]    cur;
  logic [CW-1:0] cnt, cnt_d;
  always_comb begin
    op = run ? cur : next_op(res_valid, 2'd3);
    cnt_d = run ? cnt : '0;
  end
  always_ff @(posedge clk_2) begin
    if (reset || !en) begin
      run <= 1'b0;
      cur <= 2'd0;
      cnt <= '0;
    end else begin
      run <= 1'b1;
      cur <= (cnt_d == CW'(DWELL - 1)) ? next_op(res_valid, op) : op;
      cnt <= (cnt_d == CW'(DWELL - 1)) ? '0 : cnt_d + CW'(1);
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues masked ALU ops, captures results, rotates them on LEDs; ALU_SEQ_OVF_EN enables overflow flags
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int DWELL   = 50
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       a_in,
  input  logic [2:0]       b_in,
  input  logic [3:0]       op_mask,
  output logic [7:0]       alu_word,
  input  logic [2:0]       alu_result,
  output logic             busy,
  output logic             done,
  output logic [3:0]       res_valid,
  output logic [3:0][2:0]  result,
  output logic [3:0]       ovf,
  output logic [7:0]       led_out
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DISPLAY = 2'd3;
  logic [1:0]       state, op, cnt, disp_op;
  logic [ALU_W-1:0] a, b;
  logic [3:0]       mask, rem;
  logic             ovf_new;
  alu_word_t        word;
  always_comb begin
    rem = mask & (4'b1110 << op);
    word = {a, op, b};
`ifdef ALU_SEQ_OVF_EN
    ovf_new = (op == ADD) ? (a[2] == b[2]) && (alu_result[2] != a[2]) :
              (op == SUB) ? (a[2] != b[2]) && (alu_result[2] != a[2]) : 1'b0;
`else
    ovf_new = 1'b0;
`endif
    busy = state == ISSUE || state == WAIT;
    led_out = state == DISPLAY ? {ovf[disp_op], disp_op, 2'b00, result[disp_op]} : 8'h00;
  end
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state     <= IDLE;
      alu_word  <= '0;
      done      <= 1'b0;
      res_valid <= '0;
      result    <= '0;
      ovf       <= '0;
      a         <= '0;
      b         <= '0;
      mask      <= '0;
      op        <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (start && (state == IDLE || state == DISPLAY)) begin
        a         <= a_in;
        b         <= b_in;
        mask      <= op_mask;
        res_valid <= '0;
        ovf       <= '0;
        op        <= next_op(op_mask, 2'd3);
        state     <= op_mask != 4'd0 ? ISSUE : IDLE;
        done      <= op_mask == 4'd0;
      end else if (state == ISSUE) begin
        alu_word <= word;
        cnt      <= 2'(ALU_LAT - 1);
        state    <= WAIT;
      end else if (state == WAIT) begin
        if (cnt != 2'd0) cnt <= cnt - 2'd1;
        else begin
          result[op]    <= alu_result;
          res_valid[op] <= 1'b1;
          ovf[op]       <= ovf_new;
          op            <= next_op(rem, op);
          state         <= rem != 4'd0 ? ISSUE : DISPLAY;
          done          <= rem == 4'd0;
        end
      end
    end
  end
  alu_display_rotator #(.DWELL(DWELL)) u_rot (
    .clk_2     (clk_2),
    .reset     (reset),
    .en        (state == DISPLAY),
    .res_valid (res_valid),
    .op        (disp_op)
  );
endmodule
